// File: rtl/dpram_arb_pkg.sv
// Shared types and constants for the dual-port RAM arbiter.
// Used by dpram_port_arbiter and rr_pick2.
package dpram_arb_pkg;

    localparam int NR_DEF   = 4;
    localparam int IDXW     = $clog2(NR_DEF);
    // Tag index is sized for the largest supported requester count (8).
    localparam int IDX_MAXW = 3;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic                vld;
        logic [IDX_MAXW-1:0] idx;
        port_e               port;
    } rd_tag_t;

endpackage

// File: rtl/dpram_port_arbiter_rr_pick2.sv
// Combinational round-robin picker: finds the first two valid requesters
// scanning from ptr upward (mod NR).
module rr_pick2
    import dpram_arb_pkg::*;
#(
    parameter int NR = NR_DEF,
    parameter int IW = IDXW
) (
    input  logic [NR-1:0] vld,
    input  logic [IW-1:0] ptr,
    output logic          w0_vld,
    output logic [IW-1:0] w0_idx,
    output logic          w1_vld,
    output logic [IW-1:0] w1_idx
);

    always_comb begin
        logic [IW-1:0] jj;
        w0_vld = 1'b0;
        w0_idx = '0;
        w1_vld = 1'b0;
        w1_idx = '0;
        jj     = '0;
        for (int k = 0; k < NR; k++) begin
            jj = IW'((int'(ptr) + k) % NR);
            if (vld[jj]) begin
                if (!w0_vld) begin
                    w0_vld = 1'b1;
                    w0_idx = jj;
                end else if (!w1_vld) begin
                    w1_vld = 1'b1;
                    w1_idx = jj;
                end
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between NR requesters.
// Optional same-address hazard check: define DPRAM_ARB_COLLISION_EN.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int WD = 8,
    parameter int AD = 4,
    parameter int NR = NR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NR-1:0]    req_vld,
    input  logic [NR-1:0]    req_we,
    input  logic [NR*AD-1:0] req_addr,
    input  logic [NR*WD-1:0] req_wdata,
    output logic [NR-1:0]    req_rdy,
    output logic [NR-1:0]    rsp_vld,
    output logic [NR-1:0]    rsp_port,
    output logic [WD-1:0]    rsp_rdata,
    output logic [WD-1:0]    rsp_rdata_b,
    output logic             ram_cs_n,
    output logic             ram_aw_r_n,
    output logic [AD-1:0]    ram_addr_a,
    output logic [WD-1:0]    ram_din_a,
    output logic             ram_bw_r_n,
    output logic [AD-1:0]    ram_addr_b,
    output logic [WD-1:0]    ram_din_b,
    input  logic [WD-1:0]    ram_dout_a,
    input  logic [WD-1:0]    ram_dout_b
);

    localparam int IW = $clog2(NR);

    logic [NR-1:0] vld_eff;
    logic [IW-1:0] ptr;
    logic [IW-1:0] w0_idx, w1_idx, last_idx, ptr_nxt;
    logic          w0_vld, w1_vld, g0, g1, coll;
    logic [AD-1:0] addr_arr [NR];
    logic [WD-1:0] wd_arr   [NR];
    rd_tag_t       tag_a, tag_b;

    // No grant can be issued while reset is asserted.
    assign vld_eff = rst_n ? req_vld : '0;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            addr_arr[i] = req_addr[i*AD +: AD];
            wd_arr[i]   = req_wdata[i*WD +: WD];
        end
    end

    rr_pick2 #(.NR(NR), .IW(IW)) u_pick (
        .vld    (vld_eff),
        .ptr    (ptr),
        .w0_vld (w0_vld),
        .w0_idx (w0_idx),
        .w1_vld (w1_vld),
        .w1_idx (w1_idx)
    );

`ifdef DPRAM_ARB_COLLISION_EN
    assign coll = w0_vld && w1_vld && (addr_arr[w0_idx] == addr_arr[w1_idx])
                  && (req_we[w0_idx] || req_we[w1_idx]);
`else
    assign coll = 1'b0;
`endif

    assign g0 = w0_vld;
    assign g1 = w1_vld & ~coll;

    always_comb begin
        req_rdy = '0;
        if (g0) req_rdy[w0_idx] = 1'b1;
        if (g1) req_rdy[w1_idx] = 1'b1;
    end

    // Idle ports present as a read of address 0 with zero write data.
    assign ram_cs_n   = ~(g0 | g1);
    assign ram_aw_r_n = g0 & req_we[w0_idx];
    assign ram_addr_a = g0 ? addr_arr[w0_idx] : '0;
    assign ram_din_a  = ram_aw_r_n ? wd_arr[w0_idx] : '0;
    assign ram_bw_r_n = g1 & req_we[w1_idx];
    assign ram_addr_b = g1 ? addr_arr[w1_idx] : '0;
    assign ram_din_b  = ram_bw_r_n ? wd_arr[w1_idx] : '0;

    assign last_idx = g1 ? w1_idx : w0_idx;
    assign ptr_nxt  = (last_idx == IW'(NR-1)) ? '0 : last_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            tag_a <= '0;
            tag_b <= '0;
        end else begin
            if (g0) ptr <= ptr_nxt;
            tag_a <= '{vld: g0 & ~req_we[w0_idx], idx: IDX_MAXW'(w0_idx), port: PORT_A};
            tag_b <= '{vld: g1 & ~req_we[w1_idx], idx: IDX_MAXW'(w1_idx), port: PORT_B};
        end
    end

    always_comb begin
        rsp_vld  = '0;
        rsp_port = '0;
        for (int i = 0; i < NR; i++) begin
            if (tag_a.vld && tag_a.idx == IDX_MAXW'(i)) begin
                rsp_vld[i]  = 1'b1;
                rsp_port[i] = (tag_a.port == PORT_B);
            end
            if (tag_b.vld && tag_b.idx == IDX_MAXW'(i)) begin
                rsp_vld[i]  = 1'b1;
                rsp_port[i] = (tag_b.port == PORT_B);
            end
        end
    end

    assign rsp_rdata   = tag_a.vld ? ram_dout_a : '0;
    assign rsp_rdata_b = tag_b.vld ? ram_dout_b : '0;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Self-checking bench for dpram_port_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_dpram_port_arbiter;

    localparam int WD = 8;
    localparam int AD = 4;
    localparam int NR = 4;
    localparam int DEPTH = 2**AD;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_vld, req_we, req_rdy, rsp_vld, rsp_port;
    logic [NR*AD-1:0] req_addr;
    logic [NR*WD-1:0] req_wdata;
    logic [WD-1:0]    rsp_rdata, rsp_rdata_b;
    logic             ram_cs_n, ram_aw_r_n, ram_bw_r_n;
    logic [AD-1:0]    ram_addr_a, ram_addr_b;
    logic [WD-1:0]    ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
    logic [WD-1:0]    ram [DEPTH] = '{default: '0};

    // Reference model state
    bit            p_vld [NR];
    bit            p_we  [NR];
    int            p_addr[NR];
    int            p_wd  [NR];
    int            mem   [DEPTH];
    int            m_ptr;
    bit            e_vld [NR];
    int            e_port[NR];
    int            e_data[NR];
    logic [NR-1:0] obs_rdy;
    int            n_vec = 0;
    int            n_err = 0;

    dpram_port_arbiter #(.WD(WD), .AD(AD), .NR(NR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_port    (rsp_port),
        .rsp_rdata   (rsp_rdata),
        .rsp_rdata_b (rsp_rdata_b),
        .ram_cs_n    (ram_cs_n),
        .ram_aw_r_n  (ram_aw_r_n),
        .ram_addr_a  (ram_addr_a),
        .ram_din_a   (ram_din_a),
        .ram_bw_r_n  (ram_bw_r_n),
        .ram_addr_b  (ram_addr_b),
        .ram_din_b   (ram_din_b),
        .ram_dout_a  (ram_dout_a),
        .ram_dout_b  (ram_dout_b)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous dual-port RAM
    always @(posedge clk) begin
        if (!ram_cs_n) begin
            if (ram_aw_r_n) ram[ram_addr_a] <= ram_din_a;
            else            ram_dout_a      <= ram[ram_addr_a];
            if (ram_bw_r_n) ram[ram_addr_b] <= ram_din_b;
            else            ram_dout_b      <= ram[ram_addr_b];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_vld[i]             = p_vld[i];
            req_we[i]              = p_we[i];
            req_addr[i*AD +: AD]   = AD'(p_addr[i]);
            req_wdata[i*WD +: WD]  = WD'(p_wd[i]);
        end
    endtask

    task automatic set_req(input int i, input bit we, input int addr, input int wd);
        p_vld[i]  = 1'b1;
        p_we[i]   = we;
        p_addr[i] = addr;
        p_wd[i]   = wd;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NR; i++) begin
            p_vld[i] = 1'b0;
            e_vld[i] = 1'b0;
        end
    endtask

    // One clock cycle: drive, check responses and grants at negedge,
    // advance the model, return 1 time unit after the rising edge.
    task automatic step();
        int g[$];
        int vexp;
        int rexp;
        drive();
        @(negedge clk);
        vexp = 0;
        for (int i = 0; i < NR; i++) if (e_vld[i]) vexp |= (1 << i);
        chk("rsp_vld", rsp_vld, vexp);
        for (int i = 0; i < NR; i++) begin
            if (e_vld[i]) begin
                chk("rsp_port", rsp_port[i], e_port[i]);
                chk("rsp_data", e_port[i] != 0 ? rsp_rdata_b : rsp_rdata, e_data[i]);
            end
        end
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (m_ptr + k) % NR;
            if (p_vld[j] && g.size() < 2) g.push_back(j);
        end
`ifdef DPRAM_ARB_COLLISION_EN
        if (g.size() == 2 && p_addr[g[0]] == p_addr[g[1]] && (p_we[g[0]] || p_we[g[1]]))
            void'(g.pop_back());
`endif
        rexp = 0;
        foreach (g[x]) rexp |= (1 << g[x]);
        obs_rdy = req_rdy;
        chk("req_rdy", req_rdy, rexp);
        chk("ram_cs_n", ram_cs_n, (g.size() == 0) ? 1 : 0);
        for (int i = 0; i < NR; i++) e_vld[i] = 1'b0;
        foreach (g[x]) begin
            if (!p_we[g[x]]) begin
                e_vld[g[x]]  = 1'b1;
                e_port[g[x]] = x;
                e_data[g[x]] = mem[p_addr[g[x]]];
            end
        end
        foreach (g[x]) if (p_we[g[x]]) mem[p_addr[g[x]]] = p_wd[g[x]] & 8'hff;
        if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % NR;
        foreach (g[x]) p_vld[g[x]] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 8; n++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < NR; i++) any |= p_vld[i];
            if (any) step();
        end
    endtask

    // New request for requester i that never forms a same-address pair
    // involving a write with any other pending request.
    task automatic gen(input int i);
        for (int t = 0; t < 50; t++) begin
            bit we;
            int addr;
            bit ok;
            we   = 1'($urandom_range(0, 1));
            addr = int'($urandom_range(0, DEPTH-1));
            ok   = 1'b1;
`ifndef DPRAM_ARB_COLLISION_EN
            for (int j = 0; j < NR; j++)
                if (j != i && p_vld[j] && p_addr[j] == addr && (we || p_we[j])) ok = 1'b0;
`endif
            if (ok) begin
                set_req(i, we, addr, int'($urandom_range(0, 255)));
                return;
            end
        end
    endtask

    logic [NR-1:0] fair_exp [4];

    initial begin
        fair_exp = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        for (int a = 0; a < DEPTH; a++) mem[a] = 0;
        model_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, i, 0);
        drive();
        repeat (2) @(negedge clk);
        chk("rst_rdy", req_rdy, 0);
        chk("rst_cs_n", ram_cs_n, 1);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_port", rsp_port, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_rdata_b", rsp_rdata_b, 0);
        model_reset();
        drive();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset while a read is in flight
        set_req(0, 1'b0, 5, 0);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_vld", rsp_vld, 0);
        model_reset();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();
        chk("postrst_rsp_vld", rsp_vld, 0);

        // Fairness from ptr = 0
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NR; i++) if (!p_vld[i]) set_req(i, 1'b0, i + 8, 0);
            step();
            chk("fair_grant", obs_rdy, fair_exp[c]);
        end
        drain();

        // Single writer then reader
        set_req(0, 1'b1, 3, 8'hA5);
        step();
        set_req(0, 1'b0, 3, 0);
        step();
        chk("wr_rd_vld", rsp_vld, 4'b0001);
        chk("wr_rd_port", rsp_port, 4'b0000);
        chk("wr_rd_data", rsp_rdata, 8'hA5);

        // Dual read from ptr = 0
        set_req(1, 1'b1, 1, 8'h11);
        set_req(2, 1'b1, 2, 8'h22);
        step();
        set_req(3, 1'b0, 0, 0);
        step();
        set_req(1, 1'b0, 1, 0);
        set_req(2, 1'b0, 2, 0);
        step();
        chk("dual_vld", rsp_vld, 4'b0110);
        chk("dual_port", rsp_port, 4'b0100);
        chk("dual_data_a", rsp_rdata, 8'h11);
        chk("dual_data_b", rsp_rdata_b, 8'h22);

        // Wrap-around from ptr = NR-1
        set_req(3, 1'b0, 4, 0);
        set_req(0, 1'b0, 3, 0);
        step();
        chk("wrap_grant", obs_rdy, 4'b1001);
        chk("wrap_port", rsp_port, 4'b0001);
        chk("wrap_data_b", rsp_rdata_b, 8'hA5);
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, i, 0);
        step();
        chk("wrap_ptr", obs_rdy, 4'b0110);
        drain();

`ifdef DPRAM_ARB_COLLISION_EN
        set_req(3, 1'b0, 0, 0);
        step();
        set_req(0, 1'b1, 7, 8'h5A);
        set_req(1, 1'b0, 7, 0);
        step();
        chk("coll_first", obs_rdy, 4'b0001);
        step();
        chk("coll_second", obs_rdy, 4'b0010);
        chk("coll_vld", rsp_vld, 4'b0010);
        chk("coll_data", rsp_rdata, 8'h5A);
`endif

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++)
                if (!p_vld[i] && $urandom_range(0, 1) == 1) gen(i);
            step();
        end
        drain();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
